// File: rtl/matmul_pkg.sv
// Shared encodings and types for the matmul job sequencer and its result buffer.
package matmul_pkg;
  localparam int N  = 4;
  localparam int DW = 16;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLEAR   = 3'd1;
  localparam logic [2:0] ST_COMPUTE = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_OUTPUT  = 3'd4;

  typedef logic [N*DW-1:0] row_t;
endpackage

// File: rtl/matmul_res_buf.sv
// Four-row result store: captured during drain, handed out in row order on valid/ready.
module matmul_res_buf
  import matmul_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_idx,
  input  row_t       wr_data,
  input  logic       load,
  input  logic       ready,
  output logic       valid,
  output row_t       data,
  output logic [1:0] row,
  output logic       last
);
  row_t       mem [N];
  logic [1:0] ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      valid <= 1'b0;
      ptr   <= 2'd0;
    end else begin
      if (wr_en) mem[wr_idx] <= wr_data;
      if (load) begin
        valid <= 1'b1;
        ptr   <= 2'd0;
      end else if (valid && ready) begin
        ptr <= ptr + 2'd1;
        if (ptr == 2'd3) valid <= 1'b0;
      end
    end
  end

  assign last = valid && ready && (ptr == 2'd3);
  assign data = valid ? mem[ptr] : '0;
  assign row  = ptr;
endmodule

// File: rtl/matmul_ctrl.sv
// Job sequencer for the 4x4 accumulator array: clear, stream k operand pairs, drain rows, emit results.
module matmul_ctrl
  import matmul_pkg::*;
#(
  parameter int CLR_CYCLES = 4,
  parameter int DRAIN_LAT  = 1,
  parameter int KW         = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [KW-1:0] k_len,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [KW-1:0] rd_addr,
  input  logic [63:0]   rd_a,
  input  logic [63:0]   rd_b,
  output logic [1:0]    mm_op,
  output logic [63:0]   mm_a,
  output logic [63:0]   mm_b,
  input  logic [63:0]   mm_c,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [63:0]   res_data,
  output logic [1:0]    res_row
);
  logic [2:0]    state;
  logic [KW-1:0] k_len_q;
  logic [KW-1:0] k_idx;
  logic [15:0]   phase;
  logic          clr_last, k_last, drain_last;
  logic          buf_wr, buf_load, buf_last;
  logic [1:0]    buf_idx;

  assign clr_last   = phase == 16'(CLR_CYCLES - 1);
  assign k_last     = k_idx == k_len_q - KW'(1);
  assign drain_last = phase == 16'(DRAIN_LAT + 3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      k_len_q <= '0;
      k_idx   <= '0;
      phase   <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start && k_len != '0) begin
          state   <= ST_CLEAR;
          k_len_q <= k_len;
          phase   <= '0;
        end
        ST_CLEAR: if (clr_last) begin
          state <= ST_COMPUTE;
          k_idx <= '0;
        end else phase <= phase + 16'd1;
        ST_COMPUTE: if (k_last) begin
          state <= ST_DRAIN;
          phase <= '0;
        end else k_idx <= k_idx + KW'(1);
        ST_DRAIN: if (drain_last) state <= ST_OUTPUT;
                  else phase <= phase + 16'd1;
        ST_OUTPUT: if (buf_last) begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand read runs one cycle ahead of the MAC that consumes it.
  always_comb begin
    mm_op   = OP_NOP;
    mm_a    = '0;
    mm_b    = '0;
    rd_en   = 1'b0;
    rd_addr = '0;
    case (state)
      ST_CLEAR: begin
        mm_op = OP_CLR;
        rd_en = clr_last;
      end
      ST_COMPUTE: begin
        mm_op = OP_MAC;
        mm_a  = rd_a;
        mm_b  = rd_b;
        if (!k_last) begin
          rd_en   = 1'b1;
          rd_addr = k_idx + KW'(1);
        end
      end
      default: ;
    endcase
  end

  assign busy     = state != ST_IDLE;
  assign buf_wr   = (state == ST_DRAIN) && (phase >= 16'(DRAIN_LAT));
  assign buf_idx  = 2'(phase - 16'(DRAIN_LAT));
  assign buf_load = (state == ST_DRAIN) && drain_last;

  matmul_res_buf u_res_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (buf_wr),
    .wr_idx  (buf_idx),
    .wr_data (mm_c),
    .load    (buf_load),
    .ready   (res_ready),
    .valid   (res_valid),
    .data    (res_data),
    .row     (res_row),
    .last    (buf_last)
  );
endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl with a behavioural 4x4 accumulator array and 1-cycle operand memory.
module tb_matmul_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  k_len = 8'd0;
  logic        busy, done, rd_en;
  logic [7:0]  rd_addr;
  logic [63:0] rd_a = '0, rd_b = '0;
  logic [1:0]  mm_op;
  logic [63:0] mm_a, mm_b;
  logic [63:0] mm_c = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [63:0] res_data;
  logic [1:0]  res_row;

  int cmp_cnt = 0, err_cnt = 0;
  int done_cnt = 0, clr_cnt = 0, mac_cnt = 0, rd_cnt = 0, busy_cnt = 0;
  int rd_max = 0, rd_min = 9999;
  logic [65:0] exp_q[$], got_q[$], stall_q[$];

  logic [15:0] acc [4][4];
  int          drain_ptr = 0;

  always #5 clk = ~clk;

  matmul_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_a(rd_a), .rd_b(rd_b), .mm_op(mm_op),
    .mm_a(mm_a), .mm_b(mm_b), .mm_c(mm_c), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_row(res_row)
  );

  function automatic logic [63:0] mk_a(input int k);
    logic [63:0] v;
    for (int i = 0; i < 4; i++) v[16*i +: 16] = 16'(4*i + 1 + k);
    return v;
  endfunction

  function automatic logic [63:0] mk_b(input int k);
    logic [63:0] v;
    for (int j = 0; j < 4; j++) v[16*j +: 16] = 16'(17 + j + 4*k);
    return v;
  endfunction

  // Direct sum-of-products reference with 16-bit wrap per term and per add.
  function automatic logic [63:0] ref_row(input int k, input int r);
    logic [63:0] v;
    logic [15:0] s;
    for (int j = 0; j < 4; j++) begin
      s = '0;
      for (int t = 0; t < k; t++) s = s + 16'((4*r + 1 + t) * (17 + j + 4*t));
      v[16*j +: 16] = s;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      rd_a <= '0;
      rd_b <= '0;
    end else if (rd_en) begin
      rd_a <= mk_a(int'(rd_addr));
      rd_b <= mk_b(int'(rd_addr));
    end
  end

  // Array model: row 0 appears on mm_c one cycle after the first NOP.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) acc[i][j] <= '0;
      mm_c <= '0;
      drain_ptr <= 0;
    end else if (mm_op == 2'b01) begin
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) acc[i][j] <= '0;
      drain_ptr <= 0;
    end else if (mm_op == 2'b10) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          acc[i][j] <= acc[i][j] + mm_a[16*i +: 16] * mm_b[16*j +: 16];
      drain_ptr <= 0;
    end else begin
      mm_c <= {acc[drain_ptr % 4][3], acc[drain_ptr % 4][2], acc[drain_ptr % 4][1], acc[drain_ptr % 4][0]};
      drain_ptr <= drain_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (mm_op == 2'b01) clr_cnt++;
      if (mm_op == 2'b10) mac_cnt++;
      if (rd_en) begin
        rd_cnt++;
        if (int'(rd_addr) > rd_max) rd_max = int'(rd_addr);
        if (int'(rd_addr) < rd_min) rd_min = int'(rd_addr);
      end
    end
  end

  // Drives one job and records accepted rows; cycle 1 is the cycle after the accepting edge.
  task automatic run_job(input logic [7:0] k, input int stall_row, input int stall_n,
                         input int poke_cyc, output int t_valid, output int t_done);
    int cyc, left;
    got_q.delete();
    stall_q.delete();
    t_valid = -1;
    t_done  = -1;
    left    = stall_n;
    start   = 1'b1;
    k_len   = k;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_cnt = 0; clr_cnt = 0; mac_cnt = 0; rd_cnt = 0; rd_max = 0; rd_min = 9999;
    cyc = 1;
    while (cyc < 1000) begin
      @(negedge clk);
      start = (cyc == poke_cyc);
      if (cyc == poke_cyc) k_len = 8'd7;
      if (res_valid && t_valid < 0) t_valid = cyc;
      if (done) begin
        t_done = cyc;
        break;
      end
      res_ready = !(res_valid && int'(res_row) == stall_row && left > 0);
      if (res_valid && !res_ready) begin
        left--;
        stall_q.push_back({res_row, res_data});
      end
      if (res_valid && res_ready) got_q.push_back({res_row, res_data});
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
    res_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cmp_cnt++;
    if ({busy, done, rd_en, res_valid, mm_op} !== 6'b0) begin
      err_cnt++;
      $display("FAIL reset_ctrl got=%b exp=000000", {busy, done, rd_en, res_valid, mm_op});
    end
    cmp_cnt++;
    if ({mm_a, mm_b, res_data, rd_addr, res_row} !== '0) begin
      err_cnt++;
      $display("FAIL reset_data got=%h exp=0", {mm_a, mm_b, res_data, rd_addr, res_row});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int tv, td;
    logic [65:0] e, g;
    exp_q.push_back({2'd0, 16'd280, 16'd270, 16'd260, 16'd250});
    exp_q.push_back({2'd1, 16'd696, 16'd670, 16'd644, 16'd618});
    exp_q.push_back({2'd2, 16'd1112, 16'd1070, 16'd1028, 16'd986});
    exp_q.push_back({2'd3, 16'd1528, 16'd1470, 16'd1412, 16'd1354});
    run_job(8'd4, -1, 0, -1, tv, td);
    cmp_cnt++;
    if (tv !== 14) begin err_cnt++; $display("FAIL basic_first_valid got=%0d exp=14", tv); end
    cmp_cnt++;
    if (td !== 18) begin err_cnt++; $display("FAIL basic_done got=%0d exp=18", td); end
    cmp_cnt++;
    if (mac_cnt !== 4 || rd_cnt !== 4) begin
      err_cnt++; $display("FAIL basic_mac_rd got=%0d/%0d exp=4/4", mac_cnt, rd_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
      cmp_cnt++;
      if (g !== e) begin err_cnt++; $display("FAIL basic_row got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    int tv, td;
    logic [65:0] e, g;
    for (int job = 0; job < 2; job++) begin
      for (int r = 0; r < 4; r++) exp_q.push_back({2'(r), ref_row(4, r)});
      run_job(8'd4, -1, 0, -1, tv, td);
      cmp_cnt++;
      if (clr_cnt !== 4) begin err_cnt++; $display("FAIL b2b_clear_cycles job=%0d got=%0d exp=4", job, clr_cnt); end
      cmp_cnt++;
      if (td !== 18) begin err_cnt++; $display("FAIL b2b_done job=%0d got=%0d exp=18", job, td); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
        cmp_cnt++;
        if (g !== e) begin err_cnt++; $display("FAIL b2b_row job=%0d got=%h exp=%h", job, g, e); end
      end
    end
  endtask

  task automatic test_backpressure();
    int tv, td;
    logic [65:0] e, g;
    for (int r = 0; r < 4; r++) exp_q.push_back({2'(r), ref_row(4, r)});
    run_job(8'd4, 1, 3, -1, tv, td);
    cmp_cnt++;
    if (td !== 21) begin err_cnt++; $display("FAIL bp_done got=%0d exp=21", td); end
    cmp_cnt++;
    if (stall_q.size() !== 3) begin err_cnt++; $display("FAIL bp_stall_len got=%0d exp=3", stall_q.size()); end
    while (stall_q.size() > 0) begin
      g = stall_q.pop_front();
      cmp_cnt++;
      if (g !== {2'd1, ref_row(4, 1)}) begin
        err_cnt++; $display("FAIL bp_hold got=%h exp=%h", g, {2'd1, ref_row(4, 1)});
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
      cmp_cnt++;
      if (g !== e) begin err_cnt++; $display("FAIL bp_row got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_start_filter();
    int tv, td;
    logic [65:0] e, g;
    start = 1'b1;
    k_len = 8'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_cnt = 0;
    repeat (10) @(posedge clk);
    #1;
    cmp_cnt++;
    if (busy_cnt !== 0) begin err_cnt++; $display("FAIL kzero_busy got=%0d exp=0", busy_cnt); end
    for (int r = 0; r < 4; r++) exp_q.push_back({2'(r), ref_row(4, r)});
    run_job(8'd4, -1, 0, 6, tv, td);
    cmp_cnt++;
    if (td !== 18) begin err_cnt++; $display("FAIL poke_done got=%0d exp=18", td); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
      cmp_cnt++;
      if (g !== e) begin err_cnt++; $display("FAIL poke_row got=%h exp=%h", g, e); end
    end
    busy_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    cmp_cnt++;
    if (done_cnt !== 1 || busy_cnt !== 0) begin
      err_cnt++; $display("FAIL poke_single_done got=%0d/%0d exp=1/0", done_cnt, busy_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int tv, td;
    logic [65:0] e, g;
    start = 1'b1;
    k_len = 8'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    cmp_cnt++;
    if (mm_op !== 2'b10) begin err_cnt++; $display("FAIL mid_in_compute got=%b exp=10", mm_op); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmp_cnt++;
    if ({busy, done, rd_en, res_valid, mm_op, mm_a, mm_b, res_data, rd_addr, res_row} !== '0) begin
      err_cnt++; $display("FAIL mid_reset_outputs got=%h exp=0",
        {busy, done, rd_en, res_valid, mm_op, mm_a, mm_b, res_data, rd_addr, res_row});
    end
    done_cnt = 0;
    repeat (15) @(posedge clk);
    #1;
    cmp_cnt++;
    if (done_cnt !== 0) begin err_cnt++; $display("FAIL mid_no_done got=%0d exp=0", done_cnt); end
    for (int r = 0; r < 4; r++) exp_q.push_back({2'(r), ref_row(4, r)});
    run_job(8'd4, -1, 0, -1, tv, td);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
      cmp_cnt++;
      if (g !== e) begin err_cnt++; $display("FAIL mid_row got=%h exp=%h", g, e); end
    end
  endtask

  task automatic test_k_bounds();
    int tv, td;
    logic [65:0] e, g;
    exp_q.push_back({2'd0, 16'd20, 16'd19, 16'd18, 16'd17});
    for (int r = 1; r < 4; r++) exp_q.push_back({2'(r), ref_row(1, r)});
    run_job(8'd1, -1, 0, -1, tv, td);
    cmp_cnt++;
    if (tv !== 11 || td !== 15) begin err_cnt++; $display("FAIL k1_timing got=%0d/%0d exp=11/15", tv, td); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
      cmp_cnt++;
      if (g !== e) begin err_cnt++; $display("FAIL k1_row got=%h exp=%h", g, e); end
    end
    for (int r = 0; r < 4; r++) exp_q.push_back({2'(r), ref_row(255, r)});
    run_job(8'd255, -1, 0, -1, tv, td);
    cmp_cnt++;
    if (td !== 269) begin err_cnt++; $display("FAIL k255_done got=%0d exp=269", td); end
    cmp_cnt++;
    if (rd_cnt !== 255 || rd_min !== 0 || rd_max !== 254 || mac_cnt !== 255) begin
      err_cnt++; $display("FAIL k255_reads got=cnt%0d min%0d max%0d mac%0d exp=cnt255 min0 max254 mac255",
        rd_cnt, rd_min, rd_max, mac_cnt);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) g = got_q.pop_front(); else g = 'x;
      cmp_cnt++;
      if (g !== e) begin err_cnt++; $display("FAIL k255_row got=%h exp=%h", g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_start_filter();
    test_reset_mid();
    test_k_bounds();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/matmul_ctrl.md
# matmul_ctrl

Job sequencer for the 4×4 16-bit `matmul` accumulator array. It accepts a start command with an inner dimension `k_len` and clears the array. It then streams `k_len` operand column/row pairs from the operand buffer into the array, drains the four result rows into a local buffer, and hands them out on a valid/ready stream. It sits between the operand SRAMs and the result writeback path, and is the only driver of the array's `op`, `a` and `b` inputs.

## Interface
- `CLR_CYCLES`, default 4: number of cycles `mm_op` is held at CLEAR before compute.
- `DRAIN_LAT`, default 1: cycles from the first NOP cycle until row 0 is valid on `mm_c`.
- `KW`, default 8: width of `k_len` and `rd_addr`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: job request, sampled in IDLE only.
- `k_len` in KW: inner dimension, latched on an accepted start.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `done` out 1: one-cycle pulse at job completion.
- `rd_en` out 1: operand read strobe.
- `rd_addr` out KW: operand index k.
- `rd_a` in 64: A column k, returned 1 cycle after `rd_en`.
- `rd_b` in 64: B row k, returned 1 cycle after `rd_en`.
- `mm_op` out 2: to the array's `op`. 00 = NOP/shift-out, 01 = CLEAR, 10 = MAC.
- `mm_a` out 64: to the array's `a`.
- `mm_b` out 64: to the array's `b`.
- `mm_c` in 64: array output row.
- `res_valid` out 1: result row valid.
- `res_ready` in 1: result row accepted.
- `res_data` out 64: result row. Lane j is bits [16j+15:16j].
- `res_row` out 2: row index of `res_data`.

## Operation
- States: IDLE → CLEAR → COMPUTE → DRAIN → OUTPUT → IDLE.
- IDLE:
  - `start`=1 with `k_len`≠0: latch `k_len` and go to CLEAR.
  - `start` with `k_len`=0 is ignored; `busy` stays 0.
  - `start` outside IDLE is ignored.
- CLEAR:
  - `mm_op`=01 for exactly CLR_CYCLES cycles.
  - In the last CLEAR cycle, drive `rd_en`=1 and `rd_addr`=0 as a prefetch.
- COMPUTE:
  - Lasts `k_len` cycles, j = 0..k_len-1.
  - Each cycle drives `mm_op`=10 with `mm_a`=`rd_a` and `mm_b`=`rd_b` as a combinational passthrough of index j.
  - `rd_en`=1 with `rd_addr`=j+1 for j < k_len-1, and 0 on the last COMPUTE cycle.
- DRAIN:
  - `mm_op`=00 for DRAIN_LAT+4 cycles.
  - At DRAIN cycle d = DRAIN_LAT+r (r = 0..3), capture `mm_c` into result buffer entry r.
- OUTPUT:
  - `res_valid`=1, `res_data`=buf[row], `res_row`=row, starting at row 0.
  - Row advances only on `res_valid`&`res_ready`.
  - On acceptance of row 3, go to IDLE, pulse `done` the next cycle and drop `busy` in that same cycle.
- Outside CLEAR/COMPUTE/DRAIN: `mm_op`=00, `mm_a`=`mm_b`=0. Outside the read windows: `rd_en`=0.
- The controller performs no arithmetic. All 16-bit wrap-around happens in the array and is passed through unchanged.
- `res_ready` stalls hold `res_data`/`res_row` stable. `mm_op` stays 00 while stalled; the array contents are already captured.

## Timing
- Reset (`rst_n`=0 at an edge) forces:
  - state IDLE
  - `busy`, `done`, `rd_en`, `res_valid` = 0
  - `mm_op` = 00
  - `mm_a`, `mm_b`, `res_data`, `rd_addr`, `res_row` = 0
  - result buffer = 0
- Reset mid-job abandons the job; no `done` is issued. The array's own reset is tied to ~`rst_n` at the top level.
- Cycle 0 is the edge that accepts `start`. The schedule is:
  - CLEAR: cycles 1..CLR_CYCLES.
  - COMPUTE: the next `k_len` cycles.
  - DRAIN: the next DRAIN_LAT+4 cycles.
  - OUTPUT: follows.
- With defaults and `res_ready` held 1, the first `res_valid` appears at cycle 10+k_len and `done` at cycle 14+k_len.
- `start` asserted in the same cycle as `done` is accepted, because the state is already IDLE.
- `k_len`=255 requires no special case, since `rd_addr` never exceeds k_len-1.

## Structure
- `matmul_pkg`:
  - op encodings OP_NOP=2'b00, OP_CLR=2'b01, OP_MAC=2'b10
  - state enum
  - N=4 and DW=16
- Sub-module `matmul_res_buf`: 4×64 register file with a capture port (write index) and a read pointer with valid/ready.
- The FSM and counters stay in `matmul_ctrl`.

## Test plan
All scenarios instantiate the real `matmul` and a 1-cycle-latency operand memory with rd_a[k]={13+k,9+k,5+k,1+k} and rd_b[k]={20+4k,19+4k,18+4k,17+4k}, written lane3..lane0.
- **Basic job.** `k_len`=4, `res_ready`=1 → rows 0..3 = {280,270,260,250}, {696,670,644,618}, {1112,1070,1028,986}, {1528,1470,1412,1354}. First `res_valid` at cycle 14, `done` at cycle 18.
- **Back-to-back jobs.** Run the same job twice → identical results, proving CLEAR works. Assert `mm_op`=01 for exactly 4 cycles each job.
- **Backpressure.** `res_ready` low for 3 cycles on row 1 → `res_data`/`res_row` held stable. `done` is delayed by 3 cycles and the rows are unchanged.
- **Start filtering.** `k_len`=0 → no `busy`. `start` pulsed during COMPUTE → ignored, and only one `done` is issued.
- **Reset mid-operation.** `rst_n`=0 during COMPUTE, then a new `k_len`=4 job → all outputs at reset values the cycle after reset, and the new job produces the basic-job results.
- **Inner-dimension bounds.** `k_len`=1 → rows equal the outer product of index 0, e.g. row0={20,19,18,17}. `k_len`=255 completes, with `rd_addr` spanning 0..254 and 16-bit wrap results matching the reference model.
